i2cmb_cmd_sequencer: RTL and testbench
======================================

# i2cmb_cmd_sequencer

- Hardware command sequencer in front of the I2CMB Wishbone slave.
- Accepts one high-level I2C transfer request (bus select, 7-bit address, direction, byte count) and expands it into the register-level Wishbone sequence: enable, set bus, start, address, data bytes, stop.
- Waits on the core interrupt between commands and reports completion status.
- Replaces firmware-driven CMDR/DPR polling so on-chip requesters can use the I2CMB core directly.

## Interface

Parameters:
- LEN_W, 4 — width of byte-count field; a transfer carries 1..2^LEN_W bytes (len field value + 1).
- TIMEOUT, 65535 — max cycles to wait for irq_i per command before declaring timeout.

Ports:
- clk_i  in  1  system clock; the only clock. All logic rising-edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid  in  1  transfer request valid.
- req_ready  out  1  sequencer idle and enabled; request accepted when valid&&ready.
- req_bus_id  in  4  I2C bus index.
- req_addr  in  7  I2C slave address.
- req_rw  in  1  1=read, 0=write.
- req_len  in  LEN_W  byte count minus one.
- wdata  in  8  write byte.
- wdata_valid  in  1  write byte valid.
- wdata_ready  out  1  write byte consumed this cycle.
- rdata  out  8  read byte.
- rdata_valid  out  1  one-cycle pulse per read byte.
- done_valid  out  1  one-cycle pulse at end of transfer.
- done_status  out  2  0=OK, 1=NAK, 2=ARB_LOST, 3=ERR/timeout; held until next done.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master controls.
- wb_adr_o  out  2  register address: CSR=0, DPR=1, CMDR=2, FSMR=3.
- wb_dat_o  out  8  write data.
- wb_dat_i  in  8  read data.
- wb_ack_i  in  1  Wishbone acknowledge.
- irq_i  in  1  I2CMB interrupt, level; cleared by a CMDR read.

## Operation

Wishbone access:
- One access outstanding at a time.
- cyc/stb/we/adr/dat asserted together and held stable until the cycle wb_ack_i=1 is sampled.
- Controls deassert the following cycle; at least one idle cycle between accesses.

Sequence:
- After reset, writes CSR=0xC0 (E=1, IE=1) before req_ready rises.
- A request is latched on accept. The states are then:
  - LD_BUS: DPR=bus_id.
  - CMD_SETBUS: CMDR=0x06, then WAIT.
  - CMD_START: CMDR=0x04, then WAIT.
  - LD_ADDR: DPR={addr,rw}.
  - CMD_WRADDR: CMDR=0x01, then WAIT.
  - Per byte, write direction: GET_WD (wdata_ready=1 for exactly the cycle wdata_valid is sampled high), then DPR=byte, CMDR=0x01, WAIT.
  - Per byte, read direction: CMDR=0x02 (ACK), or 0x03 (NAK) on the last byte, then WAIT, then read DPR, then rdata_valid pulse.
  - CMD_STOP: CMDR=0x05, then WAIT.
  - DONE: done_valid pulse, then return to IDLE.

WAIT:
- Idles until irq_i=1, then reads CMDR.
- Bit7 DON → continue.
- Bit6 NAK → status=NAK, jump to CMD_STOP.
- Bit5 AL → status=ARB_LOST, go to DONE without stop.
- Bit4 ERR → status=ERR, DONE.
- Timeout counter reaching TIMEOUT → status=ERR, DONE; no CMDR read.
- Priority: AL > ERR > NAK > DON.

Other rules:
- A NAK during the STOP WAIT is ignored; first error status sticks.
- The byte counter loads req_len and decrements per byte; the last byte is counter==0.

## Timing

- Reset: all outputs 0, including done_status. State = INIT (CSR write pending).
- req_ready is 1 only in IDLE. It drops the cycle after accept.
- Wishbone access latency is 1 + cycles until ack. With zero-wait ack (ack the cycle after stb), each access occupies 2 cycles including the gap.
- rdata is valid with rdata_valid, the cycle after the DPR read ack.
- rst_i mid-transfer: immediate return to INIT.
  - Any open Wishbone cycle is dropped (cyc=0 next cycle).
  - No done pulse; the bus is left for the core's own reset.
- wdata_valid low in GET_WD: the sequencer waits indefinitely. No timeout there.
- irq_i high on entry to WAIT: accepted immediately.

## Structure

- Package i2cmb_seq_pkg holds:
  - Register address constants.
  - CMDR command codes: WAIT=0, WRITE=1, READ_ACK=2, READ_NAK=3, START=4, STOP=5, SET_BUS=6.
  - CMDR status bit positions.
  - Status enum.
  - State enum.
- Sub-module i2cmb_wb_master_port: single-access Wishbone handshake with start/we/adr/dat in and busy/done/rdata out. The sequencer FSM drives only that port.

## Test plan

- Reset, ack on the 1st cycle → CSR write 0xC0 seen, then req_ready=1 at cycle ≤4.
- Write, bus 2, addr 0x22, len=1, bytes 0x5A,0xA5, all DON → Wishbone trace DPR=02, CMDR=06, CMDR=04, DPR=0x44, CMDR=01, DPR=5A, CMDR=01, DPR=A5, CMDR=01, CMDR=05; done_status=0.
- Read, addr 0x22, len=2, slave returns 0x10,0x11,0x12 → CMDR 02,02,03; rdata pulses 10,11,12 in order; DPR=0x45; status=0.
- NAK on address byte → no data commands, STOP issued, done_status=1.
- AL on START → no STOP, done_status=2, req_ready returns.
- irq_i never asserted, TIMEOUT=16 → done_status=3 after 16 cycles in WAIT; rst_i mid-transfer → cyc=0 next cycle, no done pulse, CSR rewritten.

Source files
------------

// File: rtl/i2cmb_cmd_sequencer_pkg.sv
// Shared definitions for the I2CMB command sequencer: register map,
// CMDR command codes and status bits, transfer status, FSM states.
package i2cmb_seq_pkg;

    localparam logic [1:0] ADR_CSR  = 2'd0;
    localparam logic [1:0] ADR_DPR  = 2'd1;
    localparam logic [1:0] ADR_CMDR = 2'd2;
    localparam logic [1:0] ADR_FSMR = 2'd3;

    // E=1 (core enable), IE=1 (interrupt enable)
    localparam logic [7:0] CSR_ENABLE = 8'hC0;

    typedef enum logic [2:0] {
        C_WAIT     = 3'd0,
        C_WRITE    = 3'd1,
        C_READ_ACK = 3'd2,
        C_READ_NAK = 3'd3,
        C_START    = 3'd4,
        C_STOP     = 3'd5,
        C_SET_BUS  = 3'd6
    } cmd_e;

    localparam int DON_B = 7;
    localparam int NAK_B = 6;
    localparam int AL_B  = 5;
    localparam int ERR_B = 4;

    typedef enum logic [1:0] {
        ST_OK  = 2'd0,
        ST_NAK = 2'd1,
        ST_AL  = 2'd2,
        ST_ERR = 2'd3
    } status_e;

    typedef enum logic [4:0] {
        S_INIT, S_IDLE, S_LD_BUS, S_SETBUS, S_START,
        S_LD_ADDR, S_WRADDR, S_GET_WD, S_LD_WD, S_WR,
        S_RD, S_RD_DPR, S_RD_OUT, S_STOP, S_WAIT,
        S_RD_CMDR, S_DONE
    } state_e;

    function automatic logic [7:0] cmd_byte(cmd_e c);
        return {5'd0, c};
    endfunction

    // The first error reported in a transfer wins.
    function automatic status_e stick(status_e cur, status_e nxt);
        return (cur == ST_OK) ? nxt : cur;
    endfunction

endpackage

// File: rtl/i2cmb_cmd_sequencer_if.sv
// Wishbone bus between the sequencer (master) and the I2CMB core (slave).
// Signals: cyc/stb/we/adr/dat_o from master, dat_i/ack from slave.
interface i2cmb_wb_if;
    logic       wb_cyc_o;
    logic       wb_stb_o;
    logic       wb_we_o;
    logic [1:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i;
    logic       wb_ack_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/i2cmb_cmd_sequencer_wb_master_port.sv
// Single-access Wishbone master: start/we/adr/dat in, busy/done/rdata out.
// Ports: clk_i, rst_i, request side, wb (master modport).
module i2cmb_wb_master_port (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start,
    input  logic       we,
    input  logic [1:0] adr,
    input  logic [7:0] dat,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    i2cmb_wb_if.master wb
);

    // A start is only taken while idle, so the cycle after an ack is
    // always a bus-idle gap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb.wb_cyc_o <= 1'b0;
            wb.wb_stb_o <= 1'b0;
            wb.wb_we_o  <= 1'b0;
            wb.wb_adr_o <= 2'd0;
            wb.wb_dat_o <= 8'd0;
        end else if (wb.wb_cyc_o) begin
            if (wb.wb_ack_i) begin
                wb.wb_cyc_o <= 1'b0;
                wb.wb_stb_o <= 1'b0;
                wb.wb_we_o  <= 1'b0;
                wb.wb_adr_o <= 2'd0;
                wb.wb_dat_o <= 8'd0;
            end
        end else if (start) begin
            wb.wb_cyc_o <= 1'b1;
            wb.wb_stb_o <= 1'b1;
            wb.wb_we_o  <= we;
            wb.wb_adr_o <= adr;
            wb.wb_dat_o <= dat;
        end
    end

    assign busy  = wb.wb_cyc_o;
    assign done  = wb.wb_cyc_o & wb.wb_stb_o & wb.wb_ack_i;
    assign rdata = wb.wb_dat_i;

endmodule

// File: rtl/i2cmb_cmd_sequencer.sv
// Expands one I2C transfer request into the I2CMB register sequence.
// Ports: clk_i/rst_i, req_*, wdata_*, rdata_*, done_*, wb bus, irq_i.
import i2cmb_seq_pkg::*;

module i2cmb_cmd_sequencer #(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_bus_id,
    input  logic [6:0]       req_addr,
    input  logic             req_rw,
    input  logic [LEN_W-1:0] req_len,
    input  logic [7:0]       wdata,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    output logic [7:0]       rdata,
    output logic             rdata_valid,
    output logic             done_valid,
    output logic [1:0]       done_status,
    i2cmb_wb_if.master       wb,
    input  logic             irq_i
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_e  state, state_d, ret, ret_d;
    status_e status, status_d;

    logic [3:0]       bus;
    logic [6:0]       addr;
    logic             rw;
    logic [LEN_W-1:0] cnt;
    logic [7:0]       wbyte;
    logic [TW-1:0]    timer;

    logic       acc, p_start, p_we, p_busy, p_done;
    logic [1:0] p_adr;
    logic [7:0] p_dat, p_rdata;

    i2cmb_wb_master_port u_port (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .start (p_start),
        .we    (p_we),
        .adr   (p_adr),
        .dat   (p_dat),
        .busy  (p_busy),
        .done  (p_done),
        .rdata (p_rdata),
        .wb    (wb)
    );

    assign p_start = acc & ~p_busy;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= S_INIT;
            ret    <= S_INIT;
            status <= ST_OK;
        end else begin
            state  <= state_d;
            ret    <= ret_d;
            status <= status_d;
        end
    end

    always_comb begin
        state_d     = state;
        ret_d       = ret;
        status_d    = status;
        acc         = 1'b0;
        p_we        = 1'b0;
        p_adr       = ADR_CSR;
        p_dat       = 8'd0;
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        rdata_valid = 1'b0;
        unique case (state)
            S_INIT: begin
                acc   = 1'b1;
                p_we  = 1'b1;
                p_adr = ADR_CSR;
                p_dat = CSR_ENABLE;
                if (p_done) state_d = S_IDLE;
            end
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    status_d = ST_OK;
                    state_d  = S_LD_BUS;
                end
            end
            S_LD_BUS: begin
                acc   = 1'b1;
                p_we  = 1'b1;
                p_adr = ADR_DPR;
                p_dat = {4'd0, bus};
                if (p_done) state_d = S_SETBUS;
            end
            S_SETBUS: begin
                acc   = 1'b1;
                p_we  = 1'b1;
                p_adr = ADR_CMDR;
                p_dat = cmd_byte(C_SET_BUS);
                ret_d = S_START;
                if (p_done) state_d = S_WAIT;
            end
            S_START: begin
                acc   = 1'b1;
                p_we  = 1'b1;
                p_adr = ADR_CMDR;
                p_dat = cmd_byte(C_START);
                ret_d = S_LD_ADDR;
                if (p_done) state_d = S_WAIT;
            end
            S_LD_ADDR: begin
                acc   = 1'b1;
                p_we  = 1'b1;
                p_adr = ADR_DPR;
                p_dat = {addr, rw};
                if (p_done) state_d = S_WRADDR;
            end
            S_WRADDR: begin
                acc   = 1'b1;
                p_we  = 1'b1;
                p_adr = ADR_CMDR;
                p_dat = cmd_byte(C_WRITE);
                ret_d = rw ? S_RD : S_GET_WD;
                if (p_done) state_d = S_WAIT;
            end
            S_GET_WD: begin
                wdata_ready = wdata_valid;
                if (wdata_valid) state_d = S_LD_WD;
            end
            S_LD_WD: begin
                acc   = 1'b1;
                p_we  = 1'b1;
                p_adr = ADR_DPR;
                p_dat = wbyte;
                if (p_done) state_d = S_WR;
            end
            S_WR: begin
                acc   = 1'b1;
                p_we  = 1'b1;
                p_adr = ADR_CMDR;
                p_dat = cmd_byte(C_WRITE);
                ret_d = (cnt == '0) ? S_STOP : S_GET_WD;
                if (p_done) state_d = S_WAIT;
            end
            S_RD: begin
                acc   = 1'b1;
                p_we  = 1'b1;
                p_adr = ADR_CMDR;
                p_dat = (cnt == '0) ? cmd_byte(C_READ_NAK)
                                    : cmd_byte(C_READ_ACK);
                ret_d = S_RD_DPR;
                if (p_done) state_d = S_WAIT;
            end
            S_RD_DPR: begin
                acc   = 1'b1;
                p_adr = ADR_DPR;
                if (p_done) state_d = S_RD_OUT;
            end
            S_RD_OUT: begin
                rdata_valid = 1'b1;
                state_d     = (cnt == '0) ? S_STOP : S_RD;
            end
            S_STOP: begin
                acc   = 1'b1;
                p_we  = 1'b1;
                p_adr = ADR_CMDR;
                p_dat = cmd_byte(C_STOP);
                ret_d = S_DONE;
                if (p_done) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (irq_i) begin
                    state_d = S_RD_CMDR;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    status_d = stick(status, ST_ERR);
                    state_d  = S_DONE;
                end
            end
            S_RD_CMDR: begin
                acc   = 1'b1;
                p_adr = ADR_CMDR;
                if (p_done) begin
                    if (p_rdata[AL_B]) begin
                        status_d = stick(status, ST_AL);
                        state_d  = S_DONE;
                    end else if (p_rdata[ERR_B]) begin
                        status_d = stick(status, ST_ERR);
                        state_d  = S_DONE;
                    end else if (p_rdata[NAK_B]) begin
                        // ret==S_DONE means this was the STOP wait
                        if (ret != S_DONE) begin
                            status_d = stick(status, ST_NAK);
                        end
                        state_d = (ret == S_DONE) ? S_DONE : S_STOP;
                    end else if (p_rdata[DON_B]) begin
                        state_d = ret;
                    end else begin
                        status_d = stick(status, ST_ERR);
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus         <= 4'd0;
            addr        <= 7'd0;
            rw          <= 1'b0;
            cnt         <= '0;
            wbyte       <= 8'd0;
            rdata       <= 8'd0;
            timer       <= '0;
            done_valid  <= 1'b0;
            done_status <= 2'd0;
        end else begin
            done_valid <= (state == S_DONE);
            if (state == S_DONE) done_status <= status;
            timer <= (state == S_WAIT) ? timer + 1'b1 : '0;
            if (state == S_IDLE && req_valid) begin
                bus  <= req_bus_id;
                addr <= req_addr;
                rw   <= req_rw;
                cnt  <= req_len;
            end
            if (wdata_ready) wbyte <= wdata;
            if (state == S_RD_DPR && p_done) rdata <= p_rdata;
            if ((state == S_WR && p_done) || state == S_RD_OUT) begin
                if (cnt != '0) cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2cmb_cmd_sequencer.sv
// Directed bench for i2cmb_cmd_sequencer with a small I2CMB slave model.
// Ports: none; drives the DUT request side and answers the Wishbone bus.
module tb_i2cmb_cmd_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_bus_id;
    logic [6:0] req_addr;
    logic       req_rw;
    logic [3:0] req_len;
    logic [7:0] wdata;
    logic       wdata_valid;
    logic       wdata_ready;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic       done_valid;
    logic [1:0] done_status;
    logic       irq = 1'b0;

    i2cmb_wb_if wb ();

    i2cmb_cmd_sequencer #(.LEN_W(4), .TIMEOUT(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_bus_id  (req_bus_id),
        .req_addr    (req_addr),
        .req_rw      (req_rw),
        .req_len     (req_len),
        .wdata       (wdata),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .done_valid  (done_valid),
        .done_status (done_status),
        .wb          (wb),
        .irq_i       (irq)
    );

    logic       clr = 1'b1;
    logic       ack_en = 1'b1;
    logic       irq_en = 1'b1;
    logic       wd_en = 1'b0;
    logic [7:0] resp [16];
    logic [7:0] rbytes [4];
    logic [7:0] wbytes [4];
    logic [9:0] log_q [32];
    logic [7:0] rcap [8];
    logic [7:0] cur_resp = 8'h80;
    logic [2:0] pend = 3'd0;
    logic [1:0] last_stat = 2'd0;
    int log_n = 0, cmd_n = 0, rd_idx = 0, wd_idx = 0, rc_n = 0;
    int cmdr_rd_n = 0, done_cnt = 0, cyc_n = 0, cmd_cyc = 0, done_cyc = 0;
    int wd_num = 0;
    int checks = 0, errors = 0;

    assign wb.wb_ack_i = wb.wb_cyc_o & wb.wb_stb_o & ack_en;
    assign wdata       = wbytes[wd_idx[1:0]];
    assign wdata_valid = wd_en && (wd_idx < wd_num);

    always_comb begin
        wb.wb_dat_i = 8'h00;
        if (wb.wb_adr_o == 2'd2) wb.wb_dat_i = cur_resp;
        else if (wb.wb_adr_o == 2'd1) wb.wb_dat_i = rbytes[rd_idx[1:0]];
    end

    // Slave model: logs writes, raises irq 3 cycles after a CMDR write,
    // clears it on a CMDR read, serves DPR read bytes in order.
    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (clr) begin
            log_n     <= 0;
            cmd_n     <= 0;
            rd_idx    <= 0;
            wd_idx    <= 0;
            rc_n      <= 0;
            cmdr_rd_n <= 0;
            irq       <= 1'b0;
            pend      <= 3'd0;
        end else begin
            if (pend != 3'd0) begin
                pend <= pend - 3'd1;
                if (pend == 3'd1 && irq_en) irq <= 1'b1;
            end
            if (wb.wb_ack_i) begin
                if (wb.wb_we_o) begin
                    log_q[log_n[4:0]] <= {wb.wb_adr_o, wb.wb_dat_o};
                    log_n <= log_n + 1;
                    if (wb.wb_adr_o == 2'd2) begin
                        cur_resp <= resp[cmd_n[3:0]];
                        cmd_n    <= cmd_n + 1;
                        pend     <= 3'd3;
                        cmd_cyc  <= cyc_n;
                    end
                end else if (wb.wb_adr_o == 2'd2) begin
                    irq       <= 1'b0;
                    cmdr_rd_n <= cmdr_rd_n + 1;
                end else if (wb.wb_adr_o == 2'd1) begin
                    rd_idx <= rd_idx + 1;
                end
            end
            if (wdata_ready) wd_idx <= wd_idx + 1;
            if (rdata_valid) begin
                rcap[rc_n[2:0]] <= rdata;
                rc_n <= rc_n + 1;
            end
        end
        if (done_valid) begin
            done_cnt  <= done_cnt + 1;
            last_stat <= done_status;
            done_cyc  <= cyc_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic set_resp();
        for (int i = 0; i < 16; i++) resp[i] = 8'h80;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        chk("ready_to", {31'd0, req_ready}, 1);
    endtask

    task automatic send(input logic [3:0] b, input logic [6:0] a,
                        input logic r, input logic [3:0] l);
        wait_ready();
        req_bus_id = b;
        req_addr   = a;
        req_rw     = r;
        req_len    = l;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("rdy_drop", {31'd0, req_ready}, 0);
    endtask

    task automatic wait_done(input int prev);
        int n = 0;
        while (done_cnt == prev && n < 2000) begin
            tick();
            n++;
        end
        chk("done_to", done_cnt, prev + 1);
    endtask

    logic [9:0] ew [10] = '{10'h102, 10'h206, 10'h204, 10'h144, 10'h201,
                            10'h15A, 10'h201, 10'h1A5, 10'h201, 10'h205};
    logic [9:0] er [9]  = '{10'h100, 10'h206, 10'h204, 10'h145, 10'h201,
                            10'h202, 10'h202, 10'h203, 10'h205};

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int prev;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_bus_id = 4'd0;
        req_addr   = 7'd0;
        req_rw     = 1'b0;
        req_len    = 4'd0;
        set_resp();
        for (int i = 0; i < 4; i++) begin
            rbytes[i] = 8'h00;
            wbytes[i] = 8'h00;
        end
        repeat (3) tick();
        chk("rst_out", {req_ready, done_valid, done_status, rdata_valid,
                        wdata_ready, wb.wb_cyc_o, wb.wb_stb_o,
                        wb.wb_we_o}, 0);
        chk("rst_rdata", rdata, 0);

        clr = 1'b0;
        rst = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        chk("rdy_lat", {31'd0, n <= 4}, 1);
        chk("csr_n", log_n, 1);
        chk("csr", log_q[0], 10'h0C0);

        // write two bytes, all DON
        wbytes[0] = 8'h5A;
        wbytes[1] = 8'hA5;
        wd_num = 2;
        wd_en = 1'b1;
        clear();
        prev = done_cnt;
        send(4'd2, 7'h22, 1'b0, 4'd1);
        wait_done(prev);
        chk("wr_stat", last_stat, 0);
        chk("wr_n", log_n, 10);
        for (int i = 0; i < 10; i++) chk("wr_trace", log_q[i], ew[i]);
        chk("wr_bytes", wd_idx, 2);

        // read three bytes
        wd_en = 1'b0;
        rbytes[0] = 8'h10;
        rbytes[1] = 8'h11;
        rbytes[2] = 8'h12;
        clear();
        prev = done_cnt;
        send(4'd0, 7'h22, 1'b1, 4'd2);
        wait_done(prev);
        chk("rd_stat", last_stat, 0);
        chk("rd_n", log_n, 9);
        for (int i = 0; i < 9; i++) chk("rd_trace", log_q[i], er[i]);
        chk("rd_cnt", rc_n, 3);
        for (int i = 0; i < 3; i++) chk("rd_data", rcap[i], 8'h10 + i);

        // NAK on address byte
        set_resp();
        resp[2] = 8'h40;
        wd_en = 1'b1;
        clear();
        prev = done_cnt;
        send(4'd1, 7'h33, 1'b0, 4'd0);
        wait_done(prev);
        chk("nak_stat", last_stat, 1);
        chk("nak_n", log_n, 6);
        chk("nak_stop", log_q[5], 10'h205);
        chk("nak_nodata", wd_idx, 0);

        // arbitration lost on START
        set_resp();
        resp[1] = 8'h20;
        wd_en = 1'b0;
        clear();
        prev = done_cnt;
        send(4'd1, 7'h33, 1'b0, 4'd0);
        wait_done(prev);
        chk("al_stat", last_stat, 2);
        chk("al_n", log_n, 3);
        chk("al_last", log_q[2], 10'h204);
        wait_ready();

        // irq never comes: 16 WAIT cycles, DONE, then registered pulse
        set_resp();
        irq_en = 1'b0;
        clear();
        prev = done_cnt;
        send(4'd1, 7'h10, 1'b0, 4'd0);
        wait_done(prev);
        chk("to_stat", last_stat, 3);
        chk("to_n", log_n, 2);
        chk("to_nord", cmdr_rd_n, 0);
        chk("to_cyc", done_cyc - cmd_cyc, 18);
        chk("to_hold", {30'd0, done_status}, 3);

        // reset while a Wishbone access is stalled
        irq_en = 1'b1;
        ack_en = 1'b0;
        clear();
        prev = done_cnt;
        send(4'd2, 7'h22, 1'b0, 4'd0);
        n = 0;
        while (!wb.wb_cyc_o && n < 20) begin
            tick();
            n++;
        end
        chk("cyc_open", {31'd0, wb.wb_cyc_o}, 1);
        rst = 1'b1;
        tick();
        chk("cyc_drop", {31'd0, wb.wb_cyc_o}, 0);
        chk("rst_rdy", {31'd0, req_ready}, 0);
        ack_en = 1'b1;
        clr = 1'b1;
        tick();
        rst = 1'b0;
        clr = 1'b0;
        wait_ready();
        chk("rst_csr_n", log_n, 1);
        chk("rst_csr", log_q[0], 10'h0C0);
        chk("rst_nodone", done_cnt, prev);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
